// File: rtl/mmio_channel_map_pkg.sv
// mmio_channel_map_pkg: register offsets, global addresses and channel state type
package mmio_channel_map_pkg;
  localparam logic [15:0] OFF_CTRL = 16'd0;
  localparam logic [15:0] OFF_RD = 16'd2;
  localparam logic [15:0] OFF_WR = 16'd4;
  localparam logic [15:0] OFF_NS = 16'd6;
  localparam logic [15:0] OFF_CC = 16'd8;
  localparam logic [15:0] OFF_STAT = 16'd10;
  localparam logic [15:0] OFF_CYC = 16'd12;
  localparam logic [15:0] ADDR_ID = 16'h0040;
  localparam logic [15:0] ADDR_GO_MASK = 16'h0042;
  localparam logic [15:0] ADDR_DONE_VEC = 16'h0044;
  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_ERR = 2;
  typedef enum logic {CH_IDLE, CH_BUSY} ch_state_t;
endpackage

// File: rtl/mmio_if.sv
// mmio_if: host MMIO access bundle; user is the AFU-side view
interface mmio_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;
  modport user (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
  modport host (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
endinterface

// File: rtl/mmio_channel_regs.sv
// mmio_channel_regs: one channel's config registers, go/busy/done FSM, error flag and cycle counter
module mmio_channel_regs
  import mmio_channel_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [15:0]           woff,
  input  logic [63:0]           wdata,
  input  logic                  go_mask,
  input  logic [15:0]           roff,
  input  logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SIZE_WIDTH-1:0] num_samples,
  output logic [SIZE_WIDTH-1:0] collect_cycles,
  output logic                  go,
  output logic                  done_st,
  output logic                  busy,
  output logic [63:0]           rdata
);
  ch_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [SIZE_WIDTH-1:0] ns_q, ns_d, cc_q, cc_d, cyc_q, cyc_d;
  logic go_q, go_d, done_st_q, done_st_d, err_q, err_d, done_prev_q, done_prev_d;
  logic is_busy, ctrl_wr, stat_wr, go_req, abort, done_edge, cfg_wr;
  always_comb begin
    is_busy = state_q == CH_BUSY;
    ctrl_wr = we && woff == OFF_CTRL;
    stat_wr = we && woff == OFF_STAT;
    go_req = (ctrl_wr && wdata[0]) || go_mask;
    abort = ctrl_wr && wdata[1];
    done_edge = done && !done_prev_q;
    done_prev_d = done;
    cfg_wr = we && (woff == OFF_RD || woff == OFF_WR || woff == OFF_NS || woff == OFF_CC);
    go_d = go_req && !is_busy;
    state_d = is_busy ? ((done_edge || abort) ? CH_IDLE : CH_BUSY) : (go_req ? CH_BUSY : CH_IDLE);
    done_st_d = go_d ? 1'b0 : (is_busy && done_edge) ? 1'b1 : (stat_wr && wdata[ST_DONE]) ? 1'b0 : done_st_q;
    err_d = (is_busy && (go_req || cfg_wr)) ? 1'b1 : (stat_wr && wdata[ST_ERR]) ? 1'b0 : err_q;
    rd_addr_d = (we && woff == OFF_RD && !is_busy) ? wdata[ADDR_WIDTH-1:0] : rd_addr_q;
    wr_addr_d = (we && woff == OFF_WR && !is_busy) ? wdata[ADDR_WIDTH-1:0] : wr_addr_q;
    ns_d = (we && woff == OFF_NS && !is_busy) ? wdata[SIZE_WIDTH-1:0] : ns_q;
    cc_d = (we && woff == OFF_CC && !is_busy) ? wdata[SIZE_WIDTH-1:0] : cc_q;
    cyc_d = go_d ? '0 : (is_busy && !(&cyc_q)) ? cyc_q + SIZE_WIDTH'(1) : cyc_q;
    rdata = roff == OFF_RD ? 64'(rd_addr_q) :
            roff == OFF_WR ? 64'(wr_addr_q) :
            roff == OFF_NS ? 64'(ns_q) :
            roff == OFF_CC ? 64'(cc_q) :
            roff == OFF_STAT ? {61'd0, err_q, is_busy, done_st_q} :
            roff == OFF_CYC ? 64'(cyc_q) : 64'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      ns_q <= '0;
      cc_q <= '0;
      cyc_q <= '0;
      go_q <= 1'b0;
      done_st_q <= 1'b0;
      err_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      ns_q <= ns_d;
      cc_q <= cc_d;
      cyc_q <= cyc_d;
      go_q <= go_d;
      done_st_q <= done_st_d;
      err_q <= err_d;
      done_prev_q <= done_prev_d;
    end
  end
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign num_samples = ns_q;
  assign collect_cycles = cc_q;
  assign go = go_q;
  assign done_st = done_st_q;
  assign busy = is_busy;
endmodule

// File: rtl/mmio_channel_map.sv
// mmio_channel_map: multi-channel MMIO register map; address decode, global registers, read mux
module mmio_channel_map
  import mmio_channel_map_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR  = 16'h0080,
  parameter logic [15:0] CH_STRIDE  = 16'h0010,
  parameter logic [15:0] VERSION    = 16'h0002
) (
  input  logic                              clk,
  input  logic                              rst,
  mmio_if.user                              mmio,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0] num_samples,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0] collect_cycles,
  output logic [NUM_CH-1:0]                 go,
  input  logic [NUM_CH-1:0]                 done
);
  logic [NUM_CH-1:0][15:0] woff, roff;
  logic [NUM_CH-1:0][63:0] ch_rdata;
  logic [NUM_CH-1:0] rhit, done_vec, busy_vec;
  logic gm_wr;
  logic [63:0] rmux, rd_data_q, rd_data_d;
  assign gm_wr = mmio.wr_en && mmio.wr_addr == ADDR_GO_MASK;
  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    localparam logic [15:0] A = BASE_ADDR + CH_STRIDE * 16'(c);
    assign woff[c] = mmio.wr_addr - A;
    assign roff[c] = mmio.rd_addr - A;
    assign rhit[c] = roff[c] < CH_STRIDE;
    mmio_channel_regs #(.ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) u_ch (
      .clk(clk),
      .rst(rst),
      .we(mmio.wr_en && woff[c] < CH_STRIDE),
      .woff(woff[c]),
      .wdata(mmio.wr_data),
      .go_mask(gm_wr && mmio.wr_data[c]),
      .roff(roff[c]),
      .done(done[c]),
      .rd_addr(rd_addr[c]),
      .wr_addr(wr_addr[c]),
      .num_samples(num_samples[c]),
      .collect_cycles(collect_cycles[c]),
      .go(go[c]),
      .done_st(done_vec[c]),
      .busy(busy_vec[c]),
      .rdata(ch_rdata[c])
    );
  end
  always_comb begin
    rmux = '0;
    if (mmio.rd_addr == ADDR_ID) rmux = {32'h524F_4D4D, 16'(NUM_CH), VERSION};
    if (mmio.rd_addr == ADDR_DONE_VEC) begin
      rmux[NUM_CH-1:0] = done_vec;
      rmux[16 +: NUM_CH] = busy_vec;
    end
    for (int i = 0; i < NUM_CH; i++) rmux = rmux | (rhit[i] ? ch_rdata[i] : 64'd0);
    rd_data_d = mmio.rd_en ? rmux : rd_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  end
  assign mmio.rd_data = rd_data_q;
endmodule

// File: tb/tb_mmio_channel_map.sv
// tb_mmio_channel_map: table-driven register vectors plus hand-written run/abort/reset sequences
module tb_mmio_channel_map;
  logic clk = 0, rst = 1;
  logic [3:0] go, done = '0;
  logic [3:0][63:0] rd_addr, wr_addr;
  logic [3:0][31:0] num_samples, collect_cycles;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] r;
  localparam logic [63:0] ID = 64'h524F_4D4D_0004_0002;
  mmio_if m();
  mmio_channel_map dut (.clk(clk), .rst(rst), .mmio(m), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .num_samples(num_samples), .collect_cycles(collect_cycles), .go(go), .done(done));
  always #5 clk = ~clk;
  typedef struct {logic wr; logic [15:0] addr; logic [63:0] data; logic [63:0] exp;} vec_t;
  vec_t tbl[19];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    m.wr_en = 1; m.wr_addr = a; m.wr_data = d;
    @(negedge clk);
    m.wr_en = 0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk);
    m.rd_en = 1; m.rd_addr = a;
    @(negedge clk);
    m.rd_en = 0;
    d = m.rd_data;
  endtask
  initial begin
    m.wr_en = 0; m.rd_en = 0; m.wr_addr = 0; m.rd_addr = 0; m.wr_data = 0;
    tbl = '{
      '{0, 16'h0040, 64'h0, ID},
      '{0, 16'h00A2, 64'h0, 64'h0},
      '{0, 16'h0046, 64'h0, 64'h0},
      '{1, 16'h0092, 64'hDEAD_BEEF_0000_1000, 64'h0},
      '{1, 16'h0096, 64'd256, 64'h0},
      '{0, 16'h0092, 64'h0, 64'hDEAD_BEEF_0000_1000},
      '{0, 16'h0096, 64'h0, 64'd256},
      '{1, 16'h0088, 64'hFFFF_FFFF_1234_5678, 64'h0},
      '{0, 16'h0088, 64'h0, 64'h1234_5678},
      '{1, 16'h0086, 64'd100, 64'h0},
      '{1, 16'h0040, 64'hFFFF, 64'h0},
      '{0, 16'h0040, 64'h0, ID},
      '{0, 16'h0080, 64'h0, 64'h0},
      '{0, 16'h008E, 64'h0, 64'h0},
      '{1, 16'h00BC, 64'd5, 64'h0},
      '{0, 16'h00BC, 64'h0, 64'h0},
      '{0, 16'h0042, 64'h0, 64'h0},
      '{1, 16'h0084, 64'h0123_4567_89AB_CDEF, 64'h0},
      '{0, 16'h0084, 64'h0, 64'h0123_4567_89AB_CDEF}};
    repeat (2) @(negedge clk);
    chk("reset_rd_data", m.rd_data, 0);
    chk("reset_go", 64'(go), 0);
    rst = 0;
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else begin
        rd(tbl[i].addr, r);
        chk($sformatf("vec%0d_rd_%h", i, tbl[i].addr), r, tbl[i].exp);
      end
    end
    chk("port_rd_addr1", rd_addr[1], 64'hDEAD_BEEF_0000_1000);
    chk("port_wr_addr0", wr_addr[0], 64'h0123_4567_89AB_CDEF);
    chk("port_cc0", 64'(collect_cycles[0]), 64'h1234_5678);
    // ch1 run: go pulse, busy, done after 40 busy cycles
    wr(16'h0090, 1);
    chk("ch1_go_pulse", 64'(go), 4'b0010);
    @(negedge clk);
    chk("ch1_go_one_cycle", 64'(go), 0);
    rd(16'h009A, r);
    chk("ch1_status_busy", r, 2);
    repeat (36) @(negedge clk);
    done[1] = 1;
    @(negedge clk);
    done[1] = 0;
    rd(16'h009A, r);
    chk("ch1_status_done", r, 1);
    rd(16'h009C, r);
    n_cmp++;
    if (r < 39 || r > 41) begin
      n_bad++;
      $display("FAIL ch1_cycles: got %0d expected 40+-1", r);
    end
    chk("ch1_ns_port", 64'(num_samples[1]), 256);
    // ch0 busy: second go and config write rejected
    wr(16'h0080, 1);
    chk("ch0_go_pulse", 64'(go), 4'b0001);
    wr(16'h0080, 1);
    chk("ch0_busy_go_ignored", 64'(go), 0);
    wr(16'h0086, 7);
    rd(16'h0086, r);
    chk("ch0_ns_locked", r, 100);
    rd(16'h008A, r);
    chk("ch0_status_err", r, 3'b110);
    wr(16'h008A, 3'b100);
    rd(16'h008A, r);
    chk("ch0_err_w1c", r, 3'b010);
    wr(16'h0080, 2);
    rd(16'h008A, r);
    chk("ch0_abort", r, 0);
    wr(16'h0042, 4'b1011);
    chk("go_mask_pulse", 64'(go), 4'b1011);
    rd(16'h0044, r);
    chk("done_vec_busy", r, 64'h000B_0000);
    // ch2: level done sets once; edge beats same-cycle W1C
    wr(16'h00A0, 1);
    chk("ch2_go_pulse", 64'(go), 4'b0100);
    done[2] = 1;
    repeat (10) @(negedge clk);
    done[2] = 0;
    rd(16'h00AA, r);
    chk("ch2_done_level", r, 1);
    wr(16'h00A0, 1);
    rd(16'h00AA, r);
    chk("ch2_rerun_clears_done", r, 2);
    @(negedge clk);
    done[2] = 1; m.wr_en = 1; m.wr_addr = 16'h00AA; m.wr_data = 1;
    @(negedge clk);
    done[2] = 0; m.wr_en = 0;
    rd(16'h00AA, r);
    chk("ch2_edge_beats_w1c", r, 1);
    wr(16'h00AA, 1);
    rd(16'h00AA, r);
    chk("ch2_w1c", r, 0);
    // ch1: done edge and abort in the same cycle
    @(negedge clk);
    done[1] = 1; m.wr_en = 1; m.wr_addr = 16'h0090; m.wr_data = 2;
    @(negedge clk);
    done[1] = 0; m.wr_en = 0;
    rd(16'h009A, r);
    chk("ch1_done_beats_abort", r, 1);
    wr(16'h00B0, 2);
    rd(16'h00BA, r);
    chk("ch3_abort_status", r, 0);
    rd(16'h0044, r);
    chk("done_vec_mixed", r, 64'h0001_0002);
    // reset mid-run with a go pulse in flight
    wr(16'h00A0, 1);
    chk("ch2_go_before_rst", 64'(go), 4'b0100);
    rst = 1;
    #1;
    chk("rst_drops_go", 64'(go), 0);
    @(negedge clk);
    rst = 0;
    chk("rst_outputs_zero", 64'(|{rd_addr, wr_addr, num_samples, collect_cycles, go}), 0);
    chk("rst_rd_data", m.rd_data, 0);
    rd(16'h0044, r);
    chk("rst_done_vec", r, 0);
    rd(16'h0092, r);
    chk("rst_ch1_rd_addr", r, 0);
    wr(16'h0080, 1);
    chk("post_rst_go", 64'(go), 4'b0001);
    rd(16'h008A, r);
    chk("post_rst_busy", r, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_channel_map.md
Name: mmio_channel_map

Overview:
- Multi-channel MMIO register map and control block for the AFU. It is the parametrised successor to the single-channel go/done map.
- It holds per-channel DMA configuration: rd_addr, wr_addr, num_samples and collect_cycles.
- It generates one-cycle go pulses, tracks busy/done state per channel, counts run cycles and flags protocol errors.
- It sits between the host mmio_if.user port and NUM_CH pipeline/ring-oscillator channels.

Parameters:
- NUM_CH, 4: number of independent channels (1..8).
- ADDR_WIDTH, 64: width of the rd_addr/wr_addr virtual byte addresses.
- SIZE_WIDTH, 32: width of num_samples, collect_cycles and the cycle counter.
- BASE_ADDR, 16'h0080: MMIO address of channel 0's register window.
- CH_STRIDE, 16'h0010: address distance between consecutive channel windows.
- VERSION, 16'h0002: value returned in the ID register.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- mmio  interface  mmio_if.user  host access: wr_en, wr_addr[15:0], wr_data[63:0], rd_en, rd_addr[15:0], rd_data[63:0].
- rd_addr  output  NUM_CH x ADDR_WIDTH  per-channel read address.
- wr_addr  output  NUM_CH x ADDR_WIDTH  per-channel write address.
- num_samples  output  NUM_CH x SIZE_WIDTH  per-channel cache-line count.
- collect_cycles  output  NUM_CH x SIZE_WIDTH  per-channel collection window.
- go  output  NUM_CH  one-cycle start pulse per channel.
- done  input  NUM_CH  per-channel completion pulse or level; the rising edge is used.

Behaviour:
- Global registers:
  - 16'h0040 ID (read-only): {32'h524F_4D4D, 16'(NUM_CH), VERSION}.
  - 16'h0042 GO_MASK (write-only): writes go to every channel whose bit is set in wr_data[NUM_CH-1:0].
  - 16'h0044 DONE_VEC (read-only): sticky done bits in [NUM_CH-1:0], busy bits in [NUM_CH+15:16].
- Channel c window starts at A = BASE_ADDR + c*CH_STRIDE:
  - A+0 CTRL (write): bit0 go, bit1 abort. Reads return 0.
  - A+2 rd_addr, A+4 wr_addr, A+6 num_samples, A+8 collect_cycles: read/write.
  - A+A STATUS: bit0 done (sticky, W1C), bit1 busy (read-only), bit2 err (sticky, W1C).
  - A+C CYCLES (read-only): cycle counter.
- Reset: all outputs, configuration registers, state, counters and rd_data are 0.
- Per-channel state machine:
  - IDLE: an accepted go (CTRL bit0 or its GO_MASK bit) asserts go for exactly the next cycle. In the same cycle it clears done and CYCLES, sets busy, and moves to BUSY.
  - BUSY: a done rising edge clears busy, sets done and moves to IDLE. CTRL abort clears busy and moves to IDLE without setting done.
  - A go request in BUSY is ignored: no pulse is generated and err is set.
- Configuration locking: writes to rd_addr/wr_addr/num_samples/collect_cycles while busy are discarded and set err. Outputs stay stable for the whole run.
- Done edge detect: done is registered once per channel. Edge = done & ~done_q.
- CYCLES counts +1 every cycle in BUSY, saturates at all-ones, and freezes in IDLE.
- Simultaneous events:
  - A done edge and a W1C of done in the same cycle: set wins.
  - An err set and a W1C of err in the same cycle: set wins.
  - A done edge and abort in the same cycle: done wins, so done=1.
  - GO_MASK and CTRL go in the same cycle: these are different addresses, so this cannot occur. Only one write per cycle.
- Write data: wr_data is truncated to the register width. Writes to unmapped addresses or to read-only registers have no effect.
- Reads: rd_data is registered and valid 1 cycle after rd_en. It is zero-extended, and unmapped addresses return 64'h0. rd_data holds its value when rd_en=0.
- Reset mid-run: everything returns to IDLE with zeroed registers. A go pulse in flight is dropped.

Decomposition:
- Package mmio_channel_map_pkg:
  - Register offset constants: OFF_CTRL=0, OFF_RD=2, OFF_WR=4, OFF_NS=6, OFF_CC=8, OFF_STAT=10, OFF_CYC=12.
  - Global addresses ADDR_ID, ADDR_GO_MASK, ADDR_DONE_VEC.
  - Status bit indices.
  - typedef enum logic {CH_IDLE, CH_BUSY} ch_state_t.
- Sub-module mmio_channel_regs, instantiated NUM_CH times by generate. It holds one channel's registers, state machine, edge detect and counter. It receives decoded write strobes and provides a read-mux source.
- The top level does address decode, the global registers and the read mux.

Test Plan:
- Reset, then read 16'h0040 -> 64'h524F_4D4D_0004_0002. Read ch2 rd_addr (16'h00A2) -> 0. Read an unmapped address (16'h0046) -> 0.
- Write ch1 rd_addr=64'hDEAD_BEEF_0000_1000 and num_samples=32'd256, then CTRL=1 -> go[1] high for exactly 1 cycle. STATUS(16'h009A) reads busy=1. Pulse done[1] after 40 cycles -> STATUS=1 (done) and CYCLES=40±1.
- While ch0 is busy, write CTRL go again and write num_samples=7 -> no go pulse, num_samples unchanged, STATUS=3'b110. Write STATUS=3'b100 -> err cleared.
- Write GO_MASK=4'b1011 -> go[0], go[1] and go[3] pulse in the same cycle and go[2] stays 0. DONE_VEC busy field reads 4'b1011.
- Drive done[2] high as a level for 10 cycles after a go -> done is set once. A W1C written in the same cycle as a new done edge -> done stays 1.
- Abort ch3 mid-run, then assert rst mid-run on ch0 -> ch3 STATUS=0 and idle. After rst, all outputs are 0 and a following go works normally.
